// File: rtl/btn_pkg.sv
// Shared definitions for debounced-button consumers: classifier states and timing defaults.
package btn_pkg;

  localparam int CLK_HZ          = 100_000_000;
  localparam int LONG_CYCLES_DEF = 100_000_000;  // 1.0 s at CLK_HZ
  localparam int DOUBLE_GAP_DEF  = 30_000_000;   // 0.3 s at CLK_HZ

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESSED     = 3'd1,
    LONG_HELD   = 3'd2,
    WAIT_SECOND = 3'd3,
    SECOND_HELD = 3'd4
  } btn_state_e;

endpackage

// File: rtl/button_press_classifier_if.sv
// Debounced button level in, gesture events out.
interface button_press_classifier_if;

  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       hold;
  logic [2:0] state_dbg;

  modport master (
    output btn_level,
    input  press_pulse, release_pulse, short_press, long_press, double_press, hold, state_dbg
  );

  modport slave (
    input  btn_level,
    output press_pulse, release_pulse, short_press, long_press, double_press, hold, state_dbg
  );

endinterface

// File: rtl/btn_edge_detect.sv
// One-flop edge detector for an already-synchronous, debounced level.
module btn_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_q;

  // Previous-cycle copy of the level; resets low so a level already high out of reset reads as a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) din_q <= 1'b0;
    else          din_q <= din;
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into press/release/short/long/double events.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | button up, no gesture in progress
// PRESSED     | first press held, timing toward long press
// LONG_HELD   | long press reported, hold high until release
// WAIT_SECOND | first press released, timing the gap for a second press
// SECOND_HELD | double press reported, waiting for release
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES       = LONG_CYCLES_DEF,
  parameter int DOUBLE_GAP_CYCLES = DOUBLE_GAP_DEF,
  parameter int CNT_W             = 27
) (
  input  logic                         clk,
  input  logic                         reset_n,
  button_press_classifier_if.slave     bus
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_CYCLES - 1);

  btn_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise, fall;
  logic             press_q, release_q, short_q, long_q, double_q, hold_q;
  logic             short_nxt, long_nxt, double_nxt, hold_nxt;

  btn_edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (bus.btn_level),
    .rise    (rise),
    .fall    (fall)
  );

  // State, gesture counter and all event outputs are registered together (latency 1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      press_q   <= rise;
      release_q <= fall;
      short_q   <= short_nxt;
      long_q    <= long_nxt;
      double_q  <= double_nxt;
      hold_q    <= hold_nxt;
    end
  end

  // Next-state and event decode; the counter stops at each threshold because the state is left there.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    hold_nxt   = hold_q;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end
      end
      PRESSED: begin
        // A release on the threshold cycle still counts as a short gesture.
        if (fall) begin
          state_nxt = WAIT_SECOND;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
          hold_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_nxt = IDLE;
          hold_nxt  = 1'b0;
        end
      end
      WAIT_SECOND: begin
        // A second press on the timeout cycle still wins over the short report.
        if (rise) begin
          state_nxt  = SECOND_HELD;
          double_nxt = 1'b1;
        end else if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      SECOND_HELD: begin
        if (fall) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.short_press   = short_q;
  assign bus.long_press    = long_q;
  assign bus.double_press  = double_q;
  assign bus.hold          = hold_q;
  assign bus.state_dbg     = state;

endmodule

// File: doc/button_press_classifier.md
Name: button_press_classifier

Overview:
- Sits directly downstream of the button debouncer. Consumes its clean, debounced level and classifies each gesture for the control FSMs.
- Outputs are single-cycle event pulses (press, release, short, long, double) plus a hold level.
- Replaces ad-hoc edge detection scattered across consumers of debounced buttons.

Parameters:
- LONG_CYCLES, 100_000_000: cycles the button must stay held, counted from the press, to classify as a long press (1 s at 100 MHz); must be >= 2.
- DOUBLE_GAP_CYCLES, 30_000_000: maximum release-to-second-press gap for a double press (0.3 s); must be >= 2.
- CNT_W, 27: gesture counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, DOUBLE_GAP_CYCLES).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_level  in  1  debounced button level, synchronous to clk.
- press_pulse  out  1  one cycle per rising edge of btn_level.
- release_pulse  out  1  one cycle per falling edge of btn_level.
- short_press  out  1  one cycle: single press with no second press inside the gap.
- long_press  out  1  one cycle: held for LONG_CYCLES.
- double_press  out  1  one cycle: second press inside the gap.
- hold  out  1  level: high from long_press until release.
- state_dbg  out  3  current FSM state encoding, for debug only.

Behaviour:
- Reset: asynchronous on reset_n low. All outputs 0, btn_q 0, counter 0, state IDLE. Reset mid-gesture discards the gesture and emits no pulses.
- Edge detection: btn_q <= btn_level every cycle. rise = btn_level & ~btn_q; fall = ~btn_level & btn_q.
- All outputs are registered, so every pulse appears in the cycle after the sampling edge (latency 1).
- Because btn_q resets to 0, a button already high when reset deasserts yields press_pulse on the first edge.
- press_pulse/release_pulse: driven directly from rise/fall in every state.
- FSM states: IDLE(0), PRESSED(1), LONG_HELD(2), WAIT_SECOND(3), SECOND_HELD(4).
- IDLE: on rise -> PRESSED, cnt <= 0.
- PRESSED: if fall -> WAIT_SECOND, cnt <= 0. Else if cnt == LONG_CYCLES-1 -> LONG_HELD, long_press <= 1, hold <= 1. Else cnt++.
  - Fall has priority over reaching the threshold in the same cycle (classified as short/double, not long).
- LONG_HELD: hold stays 1. On fall -> IDLE, hold <= 0. No short or double is ever produced from this gesture.
- WAIT_SECOND: if rise -> SECOND_HELD, double_press <= 1 (same cycle as press_pulse). Else if cnt == DOUBLE_GAP_CYCLES-1 -> IDLE, short_press <= 1. Else cnt++.
  - Rise has priority over timeout in the same cycle.
- SECOND_HELD: no long detection. On fall -> IDLE.
- Counter: saturates logically, because the FSM leaves the state at its threshold. It never wraps; no arithmetic exceeds CNT_W.
- At most one of short/long/double per gesture. Pulses are exactly one cycle wide.

Decomposition:
- Shared package btn_pkg holds:
  - the state enum (IDLE..SECOND_HELD, 3-bit);
  - the default constants LONG_CYCLES_DEF and DOUBLE_GAP_DEF;
  - CLK_HZ, so other button consumers use the same timing.
- One natural sub-module: btn_edge_detect (the btn_q register plus rise/fall), reusable by other debounced inputs.

Test Plan:
All tests use LONG_CYCLES=20, DOUBLE_GAP_CYCLES=10.
- Short press: btn high 5 cycles then low.
  - press_pulse 1 cycle after the rise.
  - release_pulse 1 cycle after the fall.
  - short_press exactly 10 cycles after release_pulse; long_press, double_press and hold stay 0.
- Long press: btn high 30 cycles.
  - long_press and hold rise exactly 20 cycles after press_pulse.
  - hold falls with release_pulse; no short_press follows.
- Double press: press 3 cycles, low 4, press 30 cycles.
  - double_press coincides with the second press_pulse.
  - No short_press and no long_press despite the 30-cycle hold; FSM returns to IDLE on release.
- Boundary cases:
  - Second rise arriving on the timeout cycle (cnt==9) -> double_press, no short_press.
  - Fall arriving on cnt==19 in PRESSED -> short path, no long_press.
- Reset: assert reset_n low mid-PRESSED.
  - All outputs drop to 0 asynchronously, with no clock edge needed.
  - Deassert with btn held -> press_pulse on the first edge, then the long-press timing restarts from 0.
